// File: rtl/icache_unit_if.sv
// Fetch-side and memory-side handshake bundle for icache_unit.
// slave = cache view, master = fetcher/memory view.
interface icache_unit_if;
    logic        query_en;
    logic [31:0] query_pc;
    logic        data_en;
    logic [31:0] addr_confirm;
    logic [31:0] data;
    logic        flush_signal;
    logic        mem_req_en;
    logic [31:0] mem_req_addr;
    logic        mem_data_en;
    logic [31:0] mem_data;

    modport slave (
        input  query_en, query_pc, flush_signal, mem_data_en, mem_data,
        output data_en, addr_confirm, data, mem_req_en, mem_req_addr
    );

    modport master (
        output query_en, query_pc, flush_signal, mem_data_en, mem_data,
        input  data_en, addr_confirm, data, mem_req_en, mem_req_addr
    );
endinterface

// File: rtl/icache_unit.sv
// Direct-mapped one-word-per-line instruction cache with flush-aware miss handling.
// Optional hit/miss performance counters enabled by defining ICACHE_PERF_CNT_EN.
module icache_unit #(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    icache_unit_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;
    localparam int unsigned TAG_W = 32 - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESPOND   = 2'd1,
        MISS_WAIT = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t                   state_q, state_n;
    logic [LINES-1:0]         valid_q;
    logic [TAG_W-1:0]         tag_q  [LINES];
    logic [31:0]              word_q [LINES];

    logic                     data_en_q, data_en_n;
    logic [31:0]              data_q, data_n;
    logic [31:0]              addr_q, addr_n;
    logic                     mreq_q, mreq_n;
    logic [31:0]              maddr_q, maddr_n;
    logic [31:0]              pc_q, pc_n;

    logic [INDEX_WIDTH-1:0]   q_idx, f_idx;
    logic [TAG_W-1:0]         q_tag, f_tag;
    logic                     hit_c, fill_c, hit_inc_c, miss_inc_c;

    assign q_idx = bus.query_pc[INDEX_WIDTH+1:2];
    assign q_tag = bus.query_pc[31:INDEX_WIDTH+2];
    assign f_idx = pc_q[INDEX_WIDTH+1:2];
    assign f_tag = pc_q[31:INDEX_WIDTH+2];
    assign hit_c = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

    // Next-state and registered-output logic; flush outranks a new query.
    always_comb begin
        state_n    = state_q;
        data_en_n  = 1'b0;
        data_n     = data_q;
        addr_n     = addr_q;
        mreq_n     = mreq_q;
        maddr_n    = maddr_q;
        pc_n       = pc_q;
        fill_c     = 1'b0;
        hit_inc_c  = 1'b0;
        miss_inc_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush_signal) begin
                    state_n = IDLE;
                end else if (bus.query_en) begin
                    if (hit_c) begin
                        data_en_n = 1'b1;
                        data_n    = word_q[q_idx];
                        addr_n    = bus.query_pc;
                        hit_inc_c = 1'b1;
                        state_n   = RESPOND;
                    end else begin
                        mreq_n     = 1'b1;
                        maddr_n    = {bus.query_pc[31:2], 2'b00};
                        pc_n       = bus.query_pc;
                        miss_inc_c = 1'b1;
                        state_n    = MISS_WAIT;
                    end
                end
            end
            RESPOND: begin
                state_n = IDLE;
            end
            MISS_WAIT: begin
                if (bus.mem_data_en) begin
                    fill_c = 1'b1;
                    mreq_n = 1'b0;
                    if (bus.flush_signal) begin
                        state_n = IDLE;
                    end else begin
                        data_en_n = 1'b1;
                        data_n    = bus.mem_data;
                        addr_n    = pc_q;
                        state_n   = RESPOND;
                    end
                end else if (bus.flush_signal) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_data_en) begin
                    fill_c  = 1'b1;
                    mreq_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            data_en_q <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            mreq_q    <= 1'b0;
            maddr_q   <= '0;
            pc_q      <= '0;
        end else if (rdy_in) begin
            state_q   <= state_n;
            data_en_q <= data_en_n;
            data_q    <= data_n;
            addr_q    <= addr_n;
            mreq_q    <= mreq_n;
            maddr_q   <= maddr_n;
            pc_q      <= pc_n;
            if (fill_c) valid_q[f_idx] <= 1'b1;
        end
    end

    // Tag/data storage needs no reset: valid bits gate every lookup.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_c) begin
            tag_q[f_idx]  <= f_tag;
            word_q[f_idx] <= bus.mem_data;
        end
    end

    assign bus.data_en      = data_en_q;
    assign bus.data         = data_q;
    assign bus.addr_confirm = addr_q;
    assign bus.mem_req_en   = mreq_q;
    assign bus.mem_req_addr = maddr_q;

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in) begin
            if (hit_inc_c)  hit_count  <= hit_count + 32'(1);
            if (miss_inc_c) miss_count <= miss_count + 32'(1);
        end
    end
`else
    logic unused_perf_c;
    assign unused_perf_c = hit_inc_c ^ miss_inc_c;
`endif

endmodule

// File: tb/tb_icache_unit.sv
// Self-checking bench for icache_unit: per-cycle vector table plus hand sequences
// for stall, asynchronous reset and post-reset miss behaviour.
module tb_icache_unit;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    icache_unit_if bus ();

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_unit #(.INDEX_WIDTH(6)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        q;
        logic [31:0] pc;
        logic        fl;
        logic        md_en;
        logic [31:0] md;
        logic        e_den;
        logic        e_mreq;
        logic [31:0] e_data;
        logic [31:0] e_addr;
        logic [31:0] e_maddr;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic q, input logic [31:0] pc, input logic fl,
                                input logic md_en, input logic [31:0] md,
                                input logic e_den, input logic e_mreq,
                                input logic [31:0] e_data, input logic [31:0] e_addr,
                                input logic [31:0] e_maddr);
        vec_t v;
        v.rdy = 1'b1; v.q = q; v.pc = pc; v.fl = fl; v.md_en = md_en; v.md = md;
        v.e_den = e_den; v.e_mreq = e_mreq; v.e_data = e_data; v.e_addr = e_addr;
        v.e_maddr = e_maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rdy_in           = v.rdy;
        bus.query_en     = v.q;
        bus.query_pc     = v.pc;
        bus.flush_signal = v.fl;
        bus.mem_data_en  = v.md_en;
        bus.mem_data     = v.md;
    endtask

    task automatic step_check(input int i, input vec_t v);
        drive(v);
        @(posedge clk_in);
        #1;
        chk($sformatf("v%0d data_en", i), 32'(bus.data_en), 32'(v.e_den));
        chk($sformatf("v%0d mem_req_en", i), 32'(bus.mem_req_en), 32'(v.e_mreq));
        if (v.e_den) begin
            chk($sformatf("v%0d data", i), bus.data, v.e_data);
            chk($sformatf("v%0d addr_confirm", i), bus.addr_confirm, v.e_addr);
        end
        if (v.e_mreq) chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr, v.e_maddr);
    endtask

    initial begin
        logic seen;
        // Miss/fill, hit, conflict eviction, flush-drain, flush+fill, flush priority
        vecs[0]  = mk(1, 32'h0,   0, 0, 0,            0, 1, 0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h0,   0, 0, 0,            0, 1, 0, 0, 32'h0);
        vecs[2]  = mk(1, 32'h0,   0, 0, 0,            0, 1, 0, 0, 32'h0);
        vecs[3]  = mk(1, 32'h0,   0, 1, 32'h00500093, 1, 0, 32'h00500093, 32'h0, 0);
        vecs[4]  = mk(1, 32'h0,   0, 0, 0,            0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 32'h0,   0, 0, 0,            1, 0, 32'h00500093, 32'h0, 0);
        vecs[6]  = mk(1, 32'h0,   0, 0, 0,            0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 32'h0,   0, 0, 0,            0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 32'h100, 0, 0, 0,            0, 1, 0, 0, 32'h100);
        vecs[9]  = mk(1, 32'h100, 0, 1, 32'hAAAA0001, 1, 0, 32'hAAAA0001, 32'h100, 0);
        vecs[10] = mk(1, 32'h100, 0, 0, 0,            0, 0, 0, 0, 0);
        vecs[11] = mk(1, 32'h0,   0, 0, 0,            0, 1, 0, 0, 32'h0);
        vecs[12] = mk(1, 32'h0,   0, 1, 32'h00500093, 1, 0, 32'h00500093, 32'h0, 0);
        vecs[13] = mk(1, 32'h0,   0, 0, 0,            0, 0, 0, 0, 0);
        vecs[14] = mk(1, 32'h40,  0, 0, 0,            0, 1, 0, 0, 32'h40);
        vecs[15] = mk(0, 32'h0,   1, 0, 0,            0, 1, 0, 0, 32'h40);
        vecs[16] = mk(0, 32'h0,   0, 1, 32'h12345678, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, 32'h40,  0, 0, 0,            1, 0, 32'h12345678, 32'h40, 0);
        vecs[18] = mk(1, 32'h40,  0, 0, 0,            0, 0, 0, 0, 0);
        vecs[19] = mk(1, 32'h80,  0, 0, 0,            0, 1, 0, 0, 32'h80);
        vecs[20] = mk(0, 32'h0,   1, 1, 32'hCAFEF00D, 0, 0, 0, 0, 0);
        vecs[21] = mk(1, 32'h80,  0, 0, 0,            1, 0, 32'hCAFEF00D, 32'h80, 0);
        vecs[22] = mk(0, 32'h0,   0, 0, 0,            0, 0, 0, 0, 0);
        vecs[23] = mk(1, 32'h40,  1, 0, 0,            0, 0, 0, 0, 0);
        vecs[24] = mk(1, 32'h40,  0, 0, 0,            1, 0, 32'h12345678, 32'h40, 0);
        vecs[25] = mk(1, 32'h40,  1, 0, 0,            0, 0, 0, 0, 0);
        vecs[26] = mk(0, 32'h0,   0, 0, 0,            0, 0, 0, 0, 0);

        rst_in = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("rst data_en", 32'(bus.data_en), 32'h0);
        chk("rst mem_req_en", 32'(bus.mem_req_en), 32'h0);
        chk("rst addr_confirm", bus.addr_confirm, 32'h0);
        chk("rst data", bus.data, 32'h0);
        chk("rst mem_req_addr", bus.mem_req_addr, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;

        for (int i = 0; i < NV; i++) step_check(i, vecs[i]);

        // Hit query stalled by rdy_in low for five cycles
        drive(mk(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in);
            #1;
            chk($sformatf("stall%0d data_en", i), 32'(bus.data_en), 32'h0);
        end
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("stall release data_en", 32'(bus.data_en), 32'h1);
        chk("stall release data", bus.data, 32'h00500093);
        @(posedge clk_in);
        #1;
        chk("stall no dup data_en", 32'(bus.data_en), 32'h0);

        // Asynchronous reset during MISS_WAIT
        step_check(100, mk(1, 32'hC0, 0, 0, 0, 0, 1, 0, 0, 32'hC0));
`ifdef ICACHE_PERF_CNT_EN
        chk("pre-reset hit_count", hit_count, 32'd5);
        chk("pre-reset miss_count", miss_count, 32'd6);
`endif
        #2;
        rst_in = 1'b0;
        #1;
        chk("async rst mem_req_en", 32'(bus.mem_req_en), 32'h0);
        chk("async rst data_en", 32'(bus.data_en), 32'h0);
        chk("async rst mem_req_addr", bus.mem_req_addr, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
        chk("rst hit_count", hit_count, 32'h0);
        chk("rst miss_count", miss_count, 32'h0);
`endif
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;

        // Previously cached pc=0 must miss after reset; wait for the fill response
        step_check(101, mk(1, 32'h0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
        bus.mem_data_en = 1'b1;
        bus.mem_data    = 32'h0BADF00D;
        @(posedge clk_in);
        #1;
        bus.mem_data_en = 1'b0;
        seen = bus.data_en;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk_in);
            #1;
            seen = bus.data_en;
        end
        chk("post-reset fill data_en seen", 32'(seen), 32'h1);
        chk("post-reset fill data", bus.data, 32'h0BADF00D);
        chk("post-reset fill addr_confirm", bus.addr_confirm, 32'h0);
        bus.query_en = 1'b0;
        @(posedge clk_in);
        #1;
        chk("post-reset idle data_en", 32'(bus.data_en), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_unit.md
ICACHE_UNIT -- requirements
Module: icache_unit

Interface
REQ-001 Parameter INDEX_WIDTH, default 6, meaning: log2 of line count; 1 line = 1 32-bit word.
REQ-002 clk_in  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-low.
REQ-004 rdy_in  input  1  global ready; low = freeze all state, outputs hold.
REQ-005 query_en  input  1  fetch request, held high by fetcher until data_en seen.
REQ-006 query_pc  input  32  fetch address, word-aligned; bits [1:0] ignored.
REQ-007 data_en  output  1  one-cycle pulse: data and addr_confirm valid.
REQ-008 addr_confirm  output  32  PC that data belongs to.
REQ-009 data  output  32  instruction word.
REQ-010 flush_signal  input  1  misprediction flush from RoB.
REQ-011 mem_req_en  output  1  word-read request to memory controller, level until mem_data_en.
REQ-012 mem_req_addr  output  32  word-aligned read address.
REQ-013 mem_data_en  input  1  one-cycle pulse: mem_data valid.
REQ-014 mem_data  input  32  returned word.

Function
REQ-015 Direct-mapped: index = pc[INDEX_WIDTH+1:2], tag = pc[31:INDEX_WIDTH+2]; per line valid bit, tag, 32-bit word.
REQ-016 States IDLE, RESPOND, MISS_WAIT, DRAIN; reset state IDLE.
REQ-017 IDLE, query_en=1, hit: latch data/pc into outputs, data_en=1 next cycle, go RESPOND (hit latency 1 cycle).
REQ-018 IDLE, query_en=1, miss: mem_req_en=1, mem_req_addr={pc[31:2],2'b00} next cycle, latch pc, go MISS_WAIT.
REQ-019 MISS_WAIT, mem_data_en=1: write line (valid=1, tag, word), mem_req_en=0, data_en=1 with mem_data next cycle, go RESPOND.
REQ-020 RESPOND: data_en deasserts next cycle; query_en ignored this cycle (fetcher still holds it); return IDLE.
REQ-021 data_en never high two consecutive cycles; never high without a sampled query.
REQ-022 flush_signal in IDLE/RESPOND: data_en=0 next cycle, go IDLE.
REQ-023 flush_signal in MISS_WAIT: go DRAIN, keep mem_req_en high; no data_en for that request.
REQ-024 DRAIN, mem_data_en=1: fill line normally, mem_req_en=0, data_en stays 0, go IDLE.
REQ-025 Flush and mem_data_en same cycle in MISS_WAIT: fill line, data_en=0, go IDLE.
REQ-026 Flush has priority over query_en; query arriving in flush cycle is not sampled.
REQ-027 rdy_in=0: no state, array, or output change; mem_data_en pulses during rdy_in=0 are not required to be captured (memory controller shares rdy_in).
REQ-028 Refill overwrites existing line unconditionally; no write path, no invalidate besides reset.

Reset
REQ-029 rst_in low: state IDLE, all valid bits 0, data_en=0, mem_req_en=0, addr_confirm=0, data=0, mem_req_addr=0, immediately (asynchronous).
REQ-030 Reset mid-MISS_WAIT drops request; after release first query to any pc is a miss.

Configuration
REQ-031 Macro ICACHE_PERF_CNT_EN defined: adds outputs hit_count and miss_count, 32 bits each, incremented once per served hit / issued miss (DRAIN fills count as miss), wrap at 2^32, cleared by reset.
REQ-032 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-033 Reset, query pc=0x00000000, mem returns 0x00500093 after 3 cycles -> mem_req_addr=0x0, one data_en pulse, data=0x00500093, addr_confirm=0x0.
REQ-034 Repeat query pc=0x0 -> no mem_req_en, data_en exactly 1 cycle after query sampled, data=0x00500093.
REQ-035 INDEX_WIDTH=6: fill pc=0x0, then pc=0x100 (same index) -> miss, refill; then pc=0x0 -> miss again.
REQ-036 Miss to 0x40, flush 1 cycle later, mem returns 0x12345678 -> data_en stays 0; next query 0x40 hits with 0x12345678.
REQ-037 Hit query while rdy_in held low 5 cycles -> data_en withheld, asserts 1 cycle after rdy_in rises; no duplicate pulse.
REQ-038 rst_in low during MISS_WAIT -> mem_req_en and data_en 0 immediately; ICACHE_PERF_CNT_EN build: counters read 0.
